// File: rtl/gb_timer.sv
// gb_timer: DIV/TIMA/TMA/TAC timer peripheral with delayed TIMA reload and interrupt pulse
module gb_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        wr_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        timer_irq
);
  typedef enum logic [2:0] {RUN, OVF1, OVF2, OVF3, RELOAD} state_t;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_sys_cnt;
  logic [7:0]  r_tima, r_tma, w_tima_nxt, w_tma_nxt;
  logic [2:0]  r_tac;
  logic        r_tick_q, w_tick, w_inc, w_sel_bit;
  logic        w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
  assign w_wr_div  = wr_en & (addr == 16'hFF04);
  assign w_wr_tima = wr_en & (addr == 16'hFF05);
  assign w_wr_tma  = wr_en & (addr == 16'hFF06);
  assign w_wr_tac  = wr_en & (addr == 16'hFF07);
  assign w_sel_bit = r_tac[1] ? (r_tac[0] ? r_sys_cnt[7] : r_sys_cnt[5])
                              : (r_tac[0] ? r_sys_cnt[3] : r_sys_cnt[9]);
  assign w_tick    = r_tac[2] & w_sel_bit;
  // Falling edge of the gated tick; DIV/TAC writes can create one on purpose
  assign w_inc     = r_tick_q & ~w_tick;
  // A TMA write in the reload cycle is what gets loaded into TIMA
  assign w_tma_nxt = w_wr_tma ? data_in : r_tma;
  assign timer_irq = (r_state == RELOAD);
  // Next TIMA value and overflow sequencing; CPU TIMA writes cancel a pending reload
  always_comb begin
    w_state_nxt = RUN;
    w_tima_nxt  = r_tima;
    case (r_state)
      RUN: begin
        if (w_wr_tima) w_tima_nxt = data_in;
        else if (w_inc) begin
          w_tima_nxt  = r_tima + 8'd1;
          w_state_nxt = (r_tima == 8'hFF) ? OVF1 : RUN;
        end
      end
      OVF1, OVF2, OVF3: begin
        w_state_nxt = w_wr_tima ? RUN : (r_state == OVF1) ? OVF2 : (r_state == OVF2) ? OVF3 : RELOAD;
        w_tima_nxt  = w_wr_tima ? data_in : w_inc ? r_tima + 8'd1 : r_tima;
      end
      RELOAD: w_tima_nxt = w_tma_nxt;
      default: ;
    endcase
  end
  // Register read mux
  always_comb begin
    data_out = (addr == 16'hFF04) ? r_sys_cnt[15:8] :
               (addr == 16'hFF05) ? r_tima :
               (addr == 16'hFF06) ? r_tma :
               (addr == 16'hFF07) ? {5'b11111, r_tac} : 8'hFF;
  end
  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sys_cnt <= '0;
      r_tima    <= '0;
      r_tma     <= '0;
      r_tac     <= '0;
      r_tick_q  <= 1'b0;
      r_state   <= RUN;
    end else begin
      r_sys_cnt <= w_wr_div ? 16'h0000 : r_sys_cnt + 16'd1;
      r_tima    <= w_tima_nxt;
      r_tma     <= w_tma_nxt;
      r_tac     <= w_wr_tac ? data_in[2:0] : r_tac;
      r_tick_q  <= w_tick;
      r_state   <= w_state_nxt;
    end
  end
endmodule
